pc_step_controller: RTL and testbench
=====================================

Name: pc_step_controller

Overview:
- Debug-side execution sequencer for the program counter / pipeline.
- Accepts run / step / halt / clear commands from the debug unit.
- Generates the clock-enable `db_ena` that gates PC advance, and drains the pipeline after the end-of-program flag `PC_end`.
- Counts enabled cycles for the debug unit to read back.

Parameters:
- bitsPC, 32, width of PC and breakpoint address
- CNT_W, 32, width of enabled-cycle counter
- DRAIN_CYCLES, 4, extra enabled cycles after PC_end so in-flight instructions retire (0 allowed)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- cmd_valid  in  1  command strobe from debug unit
- cmd  in  2  command code: 00 RUN, 01 STEP, 10 HALT, 11 CLEAR
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- PC_end  in  1  end-of-program flag from pipeline; sampled only while db_ena=1
- pc  in  bitsPC  current PC value (used by optional feature)
- db_ena  out  1  PC / pipeline clock enable, registered
- pipe_clear  out  1  one-cycle pipeline/PC clear pulse, registered
- done  out  1  one-cycle completion pulse, registered
- cycle_count  out  CNT_W  number of cycles with db_ena=1, saturating
- state  out  3  current FSM state encoding

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-run):
  - state=IDLE, db_ena=0, pipe_clear=0, done=0, cycle_count=0, cmd_ready=1.
- State encoding: IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4, CLR=5.
- cmd_ready:
  - 1 in IDLE, RUN and DONE.
  - 0 in STEP, DRAIN and CLR; commands presented there are not accepted.
- All outputs are registered. db_ena follows the next-state value: it goes high the cycle after a RUN/STEP is accepted.
- IDLE:
  - RUN -> RUN.
  - STEP -> STEP.
  - CLEAR -> CLR.
  - HALT is accepted with no effect.
- RUN:
  - db_ena=1 every cycle.
  - If PC_end=1 in a cycle with db_ena=1: go to DRAIN and load the drain counter with DRAIN_CYCLES.
  - HALT accepted: go to IDLE, db_ena=0 next cycle, no done pulse.
  - RUN / STEP / CLEAR are accepted and ignored.
  - PC_end and HALT in the same cycle: PC_end wins (go to DRAIN).
- STEP:
  - db_ena=1 for exactly one cycle, then IDLE with done=1 on that transition.
  - If PC_end=1 during the step cycle: go to DRAIN instead, no step done pulse.
- DRAIN:
  - db_ena=1 for DRAIN_CYCLES cycles, then DONE.
  - DRAIN_CYCLES=0: DRAIN lasts zero cycles (direct RUN/STEP -> DONE).
  - PC_end is ignored in DRAIN.
- DONE:
  - db_ena=0. done=1 on the first DONE cycle only.
  - Only CLEAR acts (-> CLR); RUN / STEP / HALT are accepted and ignored.
- CLR:
  - pipe_clear=1 for one cycle, cycle_count <- 0, then IDLE.
- cycle_count:
  - Increments on each rising edge where db_ena=1.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Cleared only by reset or the CLR state.
- Ownership of db_ena: db_ena is never asserted outside RUN, STEP and DRAIN. The PC and pipeline hold their value whenever db_ena=0.

Optional Feature:
- Macro: PC_BREAKPOINT_EN.
- When defined:
  - Adds input ports bp_valid (1) and bp_addr (bitsPC).
  - In RUN, if bp_valid=1 and pc==bp_addr while db_ena=1: next state IDLE, db_ena=0 next cycle, done=1 one cycle.
  - Priority in the same cycle: PC_end > breakpoint > HALT.
  - A RUN re-issued from IDLE with pc still equal to bp_addr executes at least one enabled cycle before the compare re-arms.
- When not defined:
  - Ports absent, no address comparator.
  - RUN exits only via PC_end or HALT.

Test Plan:
1. Reset released, RUN accepted, PC_end=1 on the 10th db_ena cycle, DRAIN_CYCLES=4 -> db_ena high exactly 14 cycles, done pulses once, state=4, cycle_count=14.
2. From IDLE, three STEP commands with a 3-cycle gap -> three single-cycle db_ena pulses, three done pulses, cycle_count=3, state returns to 0 after each.
3. RUN, then HALT after 5 enabled cycles -> db_ena low the next cycle, no done pulse, cycle_count=5; then CLEAR -> pipe_clear pulses 1 cycle, cycle_count=0, state=0.
4. PC_end and HALT in the same RUN cycle -> enters DRAIN (state=3), done after DRAIN_CYCLES; cmd_ready=0 throughout DRAIN.
5. reset driven low mid-DRAIN, asynchronously between clock edges -> db_ena, done, pipe_clear, cycle_count go to 0 immediately and state=0.
6. With PC_BREAKPOINT_EN, bp_addr=0x10 and bp_valid=1, RUN while pc counts 0x00, 0x04, ... -> db_ena drops the cycle after pc=0x10, done=1, state=0; re-RUN advances past 0x10.

Source files
------------

// File: rtl/pc_step_controller.sv
// rtl/pc_step_controller.sv - debug run/step/halt sequencer that gates PC advance
//
// Purpose:
//   Takes run / step / halt / clear commands from the debug unit and drives the
//   PC/pipeline clock enable db_ena. After the pipeline raises PC_end it keeps
//   db_ena high for DRAIN_CYCLES more cycles so in-flight instructions retire.
//   Cycles with db_ena=1 are counted (saturating) for debug read-back.
//
// Ports:
//   clk          system clock, all state on rising edge
//   reset        asynchronous active-low reset
//   cmd_valid    command strobe from debug unit
//   cmd[1:0]     00 RUN, 01 STEP, 10 HALT, 11 CLEAR
//   cmd_ready    command accepted when cmd_valid && cmd_ready
//   PC_end       end-of-program flag, only honoured while db_ena=1
//   pc           current PC (used only by the breakpoint comparator)
//   db_ena       registered PC/pipeline clock enable
//   pipe_clear   registered one-cycle pipeline/PC clear pulse
//   done         registered one-cycle completion pulse
//   cycle_count  saturating count of db_ena=1 cycles
//   state        FSM state: IDLE=0 RUN=1 STEP=2 DRAIN=3 DONE=4 CLR=5
//
// Optional feature:
//   PC_BREAKPOINT_EN - adds bp_valid / bp_addr; RUN stops (with done) when
//   pc == bp_addr while enabled. Default build has no comparator.

module pc_step_controller #(
  parameter int bitsPC       = 32,
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd,
  output logic              cmd_ready,
  input  logic              PC_end,
  input  logic [bitsPC-1:0] pc,
`ifdef PC_BREAKPOINT_EN
  input  logic              bp_valid,
  input  logic [bitsPC-1:0] bp_addr,
`endif
  output logic              db_ena,
  output logic              pipe_clear,
  output logic              done,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [2:0]        state
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_STEP  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_CLR   = 3'd5;

  localparam logic [1:0] CMD_RUN   = 2'b00;
  localparam logic [1:0] CMD_STEP  = 2'b01;
  localparam logic [1:0] CMD_HALT  = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

  // With no drain cycles the end-of-program exit skips DRAIN entirely.
  localparam logic [2:0] S_AFTER_END = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;

  logic [2:0]         state_q, state_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic               db_ena_q, db_ena_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               pipe_clear_q, pipe_clear_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;

  logic cmd_accept;
  logic exit_done;
  logic bp_hit;

  assign cmd_accept = cmd_valid && cmd_ready_q;

`ifdef PC_BREAKPOINT_EN
  // The comparator is only armed once RUN has lasted one cycle, so a RUN
  // re-issued while still sitting on the breakpoint address moves off it.
  logic bp_armed_q, bp_armed_d;

  always_comb begin
    bp_armed_d = (state_q == S_RUN);
  end

  assign bp_hit = bp_armed_q && db_ena_q && bp_valid && (pc == bp_addr);
`else
  logic unused_pc;
  assign unused_pc = ^pc;
  assign bp_hit    = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= '0;
`ifdef PC_BREAKPOINT_EN
      bp_armed_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
`ifdef PC_BREAKPOINT_EN
      bp_armed_q  <= bp_armed_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    exit_done   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_accept) begin
          case (cmd)
            CMD_RUN:   state_d = S_RUN;
            CMD_STEP:  state_d = S_STEP;
            CMD_CLEAR: state_d = S_CLR;
            default:   state_d = S_IDLE;
          endcase
        end
      end
      S_RUN: begin
        // Priority: end of program, then breakpoint, then HALT.
        if (db_ena_q && PC_end) begin
          state_d     = S_AFTER_END;
          drain_cnt_d = DRAIN_LOAD;
        end else if (bp_hit) begin
          state_d   = S_IDLE;
          exit_done = 1'b1;
        end else if (cmd_accept && (cmd == CMD_HALT)) begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        if (db_ena_q && PC_end) begin
          state_d     = S_AFTER_END;
          drain_cnt_d = DRAIN_LOAD;
        end else begin
          state_d   = S_IDLE;
          exit_done = 1'b1;
        end
      end
      S_DRAIN: begin
        // Counter holds the number of drain cycles left including this one.
        if (drain_cnt_q <= DRAIN_ONE) begin
          state_d = S_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q - DRAIN_ONE;
        end
      end
      S_DONE: begin
        if (cmd_accept && (cmd == CMD_CLEAR)) begin
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic: every output is registered from the next-state value.
  always_comb begin
    db_ena_d     = (state_d == S_RUN) || (state_d == S_STEP) || (state_d == S_DRAIN);
    cmd_ready_d  = (state_d == S_IDLE) || (state_d == S_RUN) || (state_d == S_DONE);
    pipe_clear_d = (state_d == S_CLR);
    done_d       = exit_done || ((state_d == S_DONE) && (state_q != S_DONE));

    cycle_count_d = cycle_count_q;
    if (state_d == S_CLR) begin
      cycle_count_d = '0;
    end else if (db_ena_q && (cycle_count_q != '1)) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_ena_q      <= 1'b0;
      cmd_ready_q   <= 1'b1;
      pipe_clear_q  <= 1'b0;
      done_q        <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      db_ena_q      <= db_ena_d;
      cmd_ready_q   <= cmd_ready_d;
      pipe_clear_q  <= pipe_clear_d;
      done_q        <= done_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign db_ena      = db_ena_q;
  assign cmd_ready   = cmd_ready_q;
  assign pipe_clear  = pipe_clear_q;
  assign done        = done_q;
  assign cycle_count = cycle_count_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pc_step_controller.sv
// tb/tb_pc_step_controller.sv - self-checking bench for pc_step_controller

module tb_pc_step_controller;

  localparam int BITS_PC = 32;
  localparam int CNT_W   = 5;
  localparam int DRAIN   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [1:0] C_RUN   = 2'b00;
  localparam logic [1:0] C_STEP  = 2'b01;
  localparam logic [1:0] C_HALT  = 2'b10;
  localparam logic [1:0] C_CLEAR = 2'b11;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               cmd_valid = 1'b0;
  logic [1:0]         cmd = 2'b00;
  logic               cmd_ready;
  logic               PC_end = 1'b0;
  logic [BITS_PC-1:0] pc_r;
  logic               db_ena;
  logic               pipe_clear;
  logic               done;
  logic [CNT_W-1:0]   cycle_count;
  logic [2:0]         state;
`ifdef PC_BREAKPOINT_EN
  logic               bp_valid = 1'b0;
  logic [BITS_PC-1:0] bp_addr = '0;
`endif

  int errors = 0;
  int checks = 0;
  int ena_cnt = 0;
  int done_cnt = 0;

  pc_step_controller #(
    .bitsPC(BITS_PC),
    .CNT_W(CNT_W),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd(cmd),
    .cmd_ready(cmd_ready),
    .PC_end(PC_end),
    .pc(pc_r),
`ifdef PC_BREAKPOINT_EN
    .bp_valid(bp_valid),
    .bp_addr(bp_addr),
`endif
    .db_ena(db_ena),
    .pipe_clear(pipe_clear),
    .done(done),
    .cycle_count(cycle_count),
    .state(state)
  );

  always #5 clk = ~clk;

  // Simple PC: advances by 4 on every enabled cycle, cleared by pipe_clear.
  always @(posedge clk or negedge reset) begin
    if (!reset) pc_r <= '0;
    else if (pipe_clear) pc_r <= '0;
    else if (db_ena) pc_r <= pc_r + 32'd4;
  end

  // Observation counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (db_ena) ena_cnt++;
    if (done) done_cnt++;
  end

  function automatic int sat(input int v);
    return (v > CNT_MAX) ? CNT_MAX : v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd = c;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic do_clear();
    send(C_CLEAR);
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++; if (db_ena !== 1'b0) begin errors++; $display("FAIL reset_db_ena: got %b want 0", db_ena); end
    checks++; if (pipe_clear !== 1'b0) begin errors++; $display("FAIL reset_pipe_clear: got %b want 0", pipe_clear); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (cycle_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
    #2 reset = 1'b1;
    tick();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_release_state: got %0d want 0", state); end
  endtask

  // Start with RUN or STEP, raise PC_end on the k-th enabled cycle, then drain.
  task automatic test_end_drain(input logic [1:0] start, input int k, input bit with_halt);
    int e0, d0, r;
    logic [2:0] run_state;
    run_state = (start == C_STEP) ? 3'd2 : 3'd1;
    do_clear();
    e0 = ena_cnt;
    d0 = done_cnt;
    send(start);
    for (int i = 1; i <= k; i++) begin
      checks++; if (state !== run_state || db_ena !== 1'b1) begin errors++; $display("FAIL end_run_cycle%0d: state=%0d ena=%b want state=%0d ena=1", i, state, db_ena, run_state); end
      if (i == k) begin
        PC_end = 1'b1;
        if (with_halt) begin cmd_valid = 1'b1; cmd = C_HALT; end
      end else begin
        r = $urandom_range(0, 2);
        cmd_valid = 1'($urandom_range(0, 1));
        cmd = (r == 2) ? C_CLEAR : 2'(r);
      end
      tick();
      PC_end = 1'b0;
      cmd_valid = 1'b0;
    end
    for (int j = 1; j <= DRAIN; j++) begin
      checks++; if (state !== 3'd3 || cmd_ready !== 1'b0 || db_ena !== 1'b1) begin errors++; $display("FAIL drain_cycle%0d: state=%0d ready=%b ena=%b want 3/0/1", j, state, cmd_ready, db_ena); end
      cmd_valid = 1'($urandom_range(0, 1));
      cmd = 2'($urandom_range(0, 3));
      PC_end = 1'($urandom_range(0, 1));
      tick();
      cmd_valid = 1'b0;
      PC_end = 1'b0;
    end
    checks++; if (state !== 3'd4 || done !== 1'b1 || db_ena !== 1'b0) begin errors++; $display("FAIL done_entry: state=%0d done=%b ena=%b want 4/1/0", state, done, db_ena); end
    send(2'($urandom_range(0, 2)));
    checks++; if (state !== 3'd4 || done !== 1'b0) begin errors++; $display("FAIL done_hold: state=%0d done=%b want 4/0", state, done); end
    checks++; if (ena_cnt - e0 !== k + DRAIN) begin errors++; $display("FAIL end_ena_cycles: got %0d want %0d", ena_cnt - e0, k + DRAIN); end
    checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL end_done_pulses: got %0d want 1", done_cnt - d0); end
    checks++; if (int'(cycle_count) !== sat(k + DRAIN)) begin errors++; $display("FAIL end_count: got %0d want %0d", cycle_count, sat(k + DRAIN)); end
  endtask

  task automatic test_step();
    int e0, d0;
    do_clear();
    e0 = ena_cnt;
    d0 = done_cnt;
    for (int s = 0; s < 3; s++) begin
      send(C_STEP);
      checks++; if (state !== 3'd2 || db_ena !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL step%0d_active: state=%0d ena=%b ready=%b want 2/1/0", s, state, db_ena, cmd_ready); end
      tick();
      checks++; if (state !== 3'd0 || done !== 1'b1 || db_ena !== 1'b0) begin errors++; $display("FAIL step%0d_exit: state=%0d done=%b ena=%b want 0/1/0", s, state, done, db_ena); end
      repeat (3) tick();
      checks++; if (done !== 1'b0 || state !== 3'd0) begin errors++; $display("FAIL step%0d_gap: done=%b state=%0d want 0/0", s, done, state); end
    end
    checks++; if (ena_cnt - e0 !== 3) begin errors++; $display("FAIL step_ena_cycles: got %0d want 3", ena_cnt - e0); end
    checks++; if (done_cnt - d0 !== 3) begin errors++; $display("FAIL step_done_pulses: got %0d want 3", done_cnt - d0); end
    checks++; if (cycle_count !== 5'd3) begin errors++; $display("FAIL step_count: got %0d want 3", cycle_count); end
  endtask

  task automatic run_then_halt(input int m);
    send(C_RUN);
    for (int i = 1; i <= m; i++) begin
      if (i == m) begin cmd_valid = 1'b1; cmd = C_HALT; end
      tick();
      cmd_valid = 1'b0;
    end
  endtask

  task automatic test_halt();
    int e0, d0, m;
    m = $urandom_range(1, 10);
    do_clear();
    e0 = ena_cnt;
    d0 = done_cnt;
    run_then_halt(m);
    checks++; if (db_ena !== 1'b0 || state !== 3'd0 || done !== 1'b0) begin errors++; $display("FAIL halt_exit: ena=%b state=%0d done=%b want 0/0/0", db_ena, state, done); end
    tick();
    checks++; if (done_cnt - d0 !== 0) begin errors++; $display("FAIL halt_done_pulses: got %0d want 0", done_cnt - d0); end
    checks++; if (ena_cnt - e0 !== m || int'(cycle_count) !== m) begin errors++; $display("FAIL halt_count: ena=%0d count=%0d want %0d", ena_cnt - e0, cycle_count, m); end
    send(C_HALT);
    checks++; if (state !== 3'd0 || db_ena !== 1'b0) begin errors++; $display("FAIL idle_halt: state=%0d ena=%b want 0/0", state, db_ena); end
    send(C_CLEAR);
    checks++; if (state !== 3'd5 || pipe_clear !== 1'b1 || cycle_count !== '0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL clr_cycle: state=%0d clr=%b count=%0d ready=%b want 5/1/0/0", state, pipe_clear, cycle_count, cmd_ready); end
    tick();
    checks++; if (state !== 3'd0 || pipe_clear !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL clr_exit: state=%0d clr=%b ready=%b want 0/0/1", state, pipe_clear, cmd_ready); end
  endtask

  task automatic test_saturate();
    int e0, m;
    m = $urandom_range(40, 60);
    do_clear();
    e0 = ena_cnt;
    run_then_halt(m);
    tick();
    checks++; if (ena_cnt - e0 !== m) begin errors++; $display("FAIL sat_ena_cycles: got %0d want %0d", ena_cnt - e0, m); end
    checks++; if (int'(cycle_count) !== sat(m)) begin errors++; $display("FAIL sat_count: got %0d want %0d", cycle_count, sat(m)); end
  endtask

  task automatic test_back_to_back();
    int e0, d0;
    do_clear();
    e0 = ena_cnt;
    d0 = done_cnt;
    send(C_RUN);
    send(C_HALT);
    send(C_STEP);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL b2b_step: state=%0d want 2", state); end
    tick();
    tick();
    checks++; if (ena_cnt - e0 !== 2 || done_cnt - d0 !== 1 || cycle_count !== 5'd2) begin errors++; $display("FAIL b2b_totals: ena=%0d done=%0d count=%0d want 2/1/2", ena_cnt - e0, done_cnt - d0, cycle_count); end
  endtask

  task automatic test_async_reset();
    int k;
    k = $urandom_range(1, 5);
    do_clear();
    send(C_RUN);
    for (int i = 1; i <= k; i++) begin
      if (i == k) PC_end = 1'b1;
      tick();
      PC_end = 1'b0;
    end
    tick();
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL arst_pre_state: got %0d want 3", state); end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (db_ena !== 1'b0 || done !== 1'b0 || pipe_clear !== 1'b0) begin errors++; $display("FAIL arst_outputs: ena=%b done=%b clr=%b want 0/0/0", db_ena, done, pipe_clear); end
    checks++; if (cycle_count !== '0 || state !== 3'd0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL arst_state: count=%0d state=%0d ready=%b want 0/0/1", cycle_count, state, cmd_ready); end
    @(posedge clk);
    #3 reset = 1'b1;
    tick();
    checks++; if (state !== 3'd0 || db_ena !== 1'b0) begin errors++; $display("FAIL arst_release: state=%0d ena=%b want 0/0", state, db_ena); end
  endtask

`ifdef PC_BREAKPOINT_EN
  task automatic test_breakpoint();
    do_clear();
    bp_valid = 1'b1;
    bp_addr = 32'h10;
    send(C_RUN);
    for (int i = 1; i <= 5; i++) begin
      checks++; if (db_ena !== 1'b1) begin errors++; $display("FAIL bp_run%0d: ena=%b want 1", i, db_ena); end
      tick();
    end
    checks++; if (db_ena !== 1'b0 || done !== 1'b1 || state !== 3'd0) begin errors++; $display("FAIL bp_stop: ena=%b done=%b state=%0d want 0/1/0", db_ena, done, state); end
    checks++; if (pc_r !== 32'h14) begin errors++; $display("FAIL bp_pc: got %0h want 14", pc_r); end
    bp_addr = 32'h14;
    send(C_RUN);
    tick();
    checks++; if (state !== 3'd1 || db_ena !== 1'b1 || pc_r !== 32'h18) begin errors++; $display("FAIL bp_rearm: state=%0d ena=%b pc=%0h want 1/1/18", state, db_ena, pc_r); end
    send(C_HALT);
    bp_valid = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_end_drain(C_RUN, 10, 1'b0);
    test_end_drain(C_RUN, $urandom_range(1, 12), 1'b0);
    test_end_drain(C_RUN, $urandom_range(1, 12), 1'b1);
    test_end_drain(C_STEP, 1, 1'b0);
    test_step();
    test_halt();
    test_saturate();
    test_back_to_back();
    test_async_reset();
`ifdef PC_BREAKPOINT_EN
    test_breakpoint();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
